// File: rtl/gate_response_checker.sv
// Clocked stimulus/response engine for single-gate designs: sweeps every input
// vector, waits SETTLE cycles, samples the gate and tallies mismatches.
module gate_response_checker #(
  parameter int N_IN     = 1,
  parameter int SETTLE   = 2,
  parameter int GATE_SEL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   fail_vector
);

  localparam int              ERR_W      = N_IN + 1;
  localparam logic [7:0]      SETTLE_CNT = 8'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC   = '1;

  if (GATE_SEL < 0 || GATE_SEL > 6) begin : g_bad_gate
    $error("gate_response_checker: GATE_SEL=%0d selects no known gate", GATE_SEL);
  end
  if (N_IN < 1 || N_IN > 8) begin : g_bad_width
    $error("gate_response_checker: N_IN=%0d outside 1..8", N_IN);
  end
  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("gate_response_checker: SETTLE=%0d outside 1..255", SETTLE);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t     state, state_next;
  logic [7:0] cnt;
  logic       first_fail;
  logic       expected;
  logic       load, advance, mismatch;

  // Reference truth table for the selected gate.
  always_comb begin
    unique case (GATE_SEL)
      0:       expected = ~dut_in[0];
      1:       expected = &dut_in;
      2:       expected = |dut_in;
      3:       expected = ^dut_in;
      4:       expected = ~&dut_in;
      5:       expected = ~|dut_in;
      6:       expected = ~^dut_in;
      default: expected = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    mismatch   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == 8'd1) state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        // Case inequality so an X/Z gate output is caught as a failure in simulation.
        mismatch = (dut_out !== expected);
        if (dut_in == LAST_VEC) begin
          state_next = S_DONE;
        end else begin
          advance    = 1'b1;
          state_next = S_SETTLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in      <= '0;
      cnt         <= 8'd0;
      err_count   <= '0;
      fail_vector <= '0;
      first_fail  <= 1'b0;
    end else if (load) begin
      dut_in      <= '0;
      cnt         <= SETTLE_CNT;
      err_count   <= '0;
      fail_vector <= '0;
      first_fail  <= 1'b0;
    end else begin
      if (state == S_SETTLE) cnt <= cnt - 8'd1;
      if (mismatch) begin
        err_count <= err_count + ERR_W'(1);
        if (!first_fail) begin
          fail_vector <= dut_in;
          first_fail  <= 1'b1;
        end
      end
      if (advance) begin
        dut_in <= dut_in + N_IN'(1);
        cnt    <= SETTLE_CNT;
      end
    end
  end

  assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: a NOT checker (N_IN=1) and an
// XOR checker (N_IN=3) driven against behavioural gates with injectable faults.
module tb_gate_response_checker;

  localparam int S = 2;

  typedef struct {
    int done_cyc;
    int errs;
    int fvec;
    int pass;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_bad = 0;

  logic       rst1, start1, dout1, busy1, done1, pass1;
  logic [0:0] din1, fv1;
  logic [1:0] err1;
  logic       rst3, start3, dout3, busy3, done3, pass3;
  logic [2:0] din3, fv3;
  logic [3:0] err3;
  int         fault1, fault3;

  exp_t q1[$], q3[$];
  int   v1_q[$], v3_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gates under test: 0 good, 1 stuck-at-0, 2 buffer (NOT); XOR fault flips vector 5.
  assign dout1 = (fault1 == 0) ? ~din1[0] : (fault1 == 1) ? 1'b0 : din1[0];
  assign dout3 = (^din3) ^ (fault3 != 0 && din3 == 3'd5);

  gate_response_checker #(.N_IN(1), .SETTLE(S), .GATE_SEL(0)) u_not (
    .clk(clk), .rst(rst1), .start(start1), .dut_in(din1), .dut_out(dout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vector(fv1)
  );

  gate_response_checker #(.N_IN(3), .SETTLE(S), .GATE_SEL(3)) u_xor (
    .clk(clk), .rst(rst3), .start(start3), .dut_in(din3), .dut_out(dout3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vector(fv3)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push1(input int sc);
    exp_t e;
    int   gate, ref_bit;
    e.done_cyc = sc + 1 + 2 * (S + 1);
    e.errs = 0;
    e.fvec = 0;
    for (int v = 0; v < 2; v++) begin
      ref_bit = (v == 0) ? 1 : 0;
      gate    = (fault1 == 0) ? ref_bit : (fault1 == 1) ? 0 : v;
      if (gate != ref_bit) begin
        if (e.errs == 0) e.fvec = v;
        e.errs++;
      end
      v1_q.push_back(v);
    end
    e.pass = (e.errs == 0) ? 1 : 0;
    q1.push_back(e);
  endtask

  task automatic push3(input int sc);
    exp_t e;
    int   gate, ref_bit;
    e.done_cyc = sc + 1 + 8 * (S + 1);
    e.errs = 0;
    e.fvec = 0;
    for (int v = 0; v < 8; v++) begin
      ref_bit = $countones(v) % 2;
      gate    = (fault3 != 0 && v == 5) ? 1 - ref_bit : ref_bit;
      if (gate != ref_bit) begin
        if (e.errs == 0) e.fvec = v;
        e.errs++;
      end
      v3_q.push_back(v);
    end
    e.pass = (e.errs == 0) ? 1 : 0;
    q3.push_back(e);
  endtask

  task automatic sweep1();
    @(posedge clk); #1 start1 = 1'b1; push1(cyc);
    @(posedge clk); #1 start1 = 1'b0;
  endtask

  task automatic sweep3();
    @(posedge clk); #1 start3 = 1'b1; push3(cyc);
    @(posedge clk); #1 start3 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (which == 1) ? done1 : done3;
    end
    if (!seen) check($sformatf("timeout_done%0d", which), 0, 1);
  endtask

  // Result monitors: pop the expected record on each rising done.
  logic done1_d = 1'b0, busy1_d = 1'b0, done3_d = 1'b0, busy3_d = 1'b0;
  logic [0:0] din1_d = '0;
  logic [2:0] din3_d = '0;

  always @(negedge clk) begin
    exp_t e;
    int   v;
    if (done1 && !done1_d) begin
      if (q1.size() == 0) check("not_unexpected_done", cyc, -1);
      else begin
        e = q1.pop_front();
        check("not_done_cycle", cyc, e.done_cyc);
        check("not_err_count", int'(err1), e.errs);
        check("not_fail_vector", int'(fv1), e.fvec);
        check("not_pass", int'(pass1), e.pass);
        check("not_busy_at_done", int'(busy1), 0);
      end
    end
    if (busy1 && (!busy1_d || din1 != din1_d)) begin
      if (v1_q.size() == 0) check("not_unexpected_vector", int'(din1), -1);
      else begin
        v = v1_q.pop_front();
        check("not_vector", int'(din1), v);
      end
    end
    done1_d <= done1;
    busy1_d <= busy1;
    din1_d  <= din1;
  end

  always @(negedge clk) begin
    exp_t e;
    int   v;
    if (done3 && !done3_d) begin
      if (q3.size() == 0) check("xor_unexpected_done", cyc, -1);
      else begin
        e = q3.pop_front();
        check("xor_done_cycle", cyc, e.done_cyc);
        check("xor_err_count", int'(err3), e.errs);
        check("xor_fail_vector", int'(fv3), e.fvec);
        check("xor_pass", int'(pass3), e.pass);
      end
    end
    if (busy3 && (!busy3_d || din3 != din3_d)) begin
      if (v3_q.size() == 0) check("xor_unexpected_vector", int'(din3), -1);
      else begin
        v = v3_q.pop_front();
        check("xor_vector", int'(din3), v);
      end
    end
    done3_d <= done3;
    busy3_d <= busy3;
    din3_d  <= din3;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; start1 = 1'b0; start3 = 1'b0;
    fault1 = 0; fault3 = 0;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("rst_dut_in", int'(din1), 0);
    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_pass", int'(pass1), 0);
    check("rst_err", int'(err1), 0);
    check("rst_fv", int'(fv1), 0);
    check("rst_xor_busy_done", int'({busy3, done3, pass3}), 0);

    // Good inverter, stuck-at-0 output, then a buffer in its place.
    fault1 = 0; sweep1(); wait_done(1, 40);
    fault1 = 1; sweep1(); wait_done(1, 40);
    fault1 = 2; sweep1(); wait_done(1, 40);

    // Restart from DONE: counters clear on the very next cycle.
    sweep1();
    @(negedge clk);
    check("restart_busy", int'(busy1), 1);
    check("restart_done", int'(done1), 0);
    check("restart_err", int'(err1), 0);
    check("restart_fv", int'(fv1), 0);
    wait_done(1, 40);

    // start held through the sweep: ignored while busy, restarts after done.
    fault1 = 0;
    @(posedge clk); #1 start1 = 1'b1; push1(cyc);
    wait_done(1, 40);
    @(posedge clk); #1 push1(cyc - 1); start1 = 1'b0;
    @(negedge clk);
    check("held_restart_busy", int'(busy1), 1);
    check("held_restart_done", int'(done1), 0);
    wait_done(1, 40);

    // Reset in cycle 4 of a sweep.
    sweep1();
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b1;
    @(posedge clk);
    q1.delete();
    v1_q.delete();
    #1 rst1 = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy1), 0);
    check("midrst_done", int'(done1), 0);
    check("midrst_dut_in", int'(din1), 0);
    check("midrst_err", int'(err1), 0);
    check("midrst_pass", int'(pass1), 0);
    sweep1(); wait_done(1, 40);

    // rst and start together: rst wins, block stays idle.
    @(posedge clk); #1 rst1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1 rst1 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    check("rst_start_busy", int'(busy1), 0);
    check("rst_start_done", int'(done1), 0);
    @(negedge clk);
    check("rst_start_busy_later", int'(busy1), 0);

    // 3-input XOR: good gate, then vector 5 corrupted.
    fault3 = 0; sweep3(); wait_done(3, 100);
    fault3 = 1; sweep3(); wait_done(3, 100);

    repeat (2) @(negedge clk);
    check("not_results_left", q1.size(), 0);
    check("not_vectors_left", v1_q.size(), 0);
    check("xor_results_left", q3.size(), 0);
    check("xor_vectors_left", v3_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Self-checking stimulus/response engine for the single-gate lab designs. On `start` it drives every input combination onto a combinational gate under test, waits a fixed settle time, samples the gate's output, and compares it against the expected truth-table value. It counts mismatches, records the first failing vector, and reports pass/fail. It sits opposite the gate under test: it replaces the hand-written `#delay` stimulus with a clocked, synthesizable driver/checker.

## Interface
- `N_IN`, default 1: stimulus width (number of gate inputs). Legal range 1..8.
- `SETTLE`, default 2: number of clock cycles each vector is held before sampling. Legal range 1..255.
- `GATE_SEL`, default 0: expected function. 0=NOT (`~in[0]`), 1=AND, 2=OR, 3=XOR, 4=NAND, 5=NOR, 6=XNOR. Functions 1..6 are reductions over all `N_IN` bits. Values 7 and above are illegal and flagged by an elaboration error.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a full sweep. Sampled only in IDLE or DONE.
- `dut_in`, output, `N_IN`: registered stimulus to the gate under test.
- `dut_out`, input, 1: gate under test output.
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: level; high from sweep completion until the next accepted `start` or `rst`.
- `pass`, output, 1: `done && (err_count == 0)`.
- `err_count`, output, `N_IN+1`: number of mismatching vectors. Its maximum is 2^N_IN, so it cannot overflow.
- `fail_vector`, output, `N_IN`: `dut_in` value of the first mismatch. Holds 0 if there were no mismatches.

## Operation
States are IDLE, SETTLE, SAMPLE and DONE.
- **IDLE.** On `start=1`: load `dut_in<=0`, `err_count<=0`, `fail_vector<=0`, `cnt<=SETTLE`, clear the first-fail flag, and go to SETTLE.
- **SETTLE.** `cnt` decrements each cycle. When `cnt==1`, go to SAMPLE. Exactly `SETTLE` cycles are spent in this state per vector.
- **SAMPLE.** Compare `dut_out` with `expected(dut_in)`.
  - On mismatch: `err_count++`. If this is the first mismatch, set `fail_vector<=dut_in` and set the first-fail flag.
  - If `dut_in == 2^N_IN-1`, go to DONE.
  - Otherwise `dut_in<=dut_in+1`, `cnt<=SETTLE`, and go to SETTLE.
- **DONE.** `done=1`, and `dut_in` holds its last value. `start=1` restarts the sweep exactly as from IDLE, and `done` drops on that edge.
- `start` is ignored while `busy` is high.
- `busy` is high in SETTLE and SAMPLE only.
- `dut_out` values of X or Z count as a mismatch in simulation. The comparison uses case-inequality.
- The `dut_in` increment never wraps within a sweep, because the terminal vector exits to DONE first.
- `rst` overrides everything, including `start` in the same cycle, and takes effect mid-sweep: it returns to IDLE and clears all outputs.

## Timing
- Reset values: `dut_in=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `fail_vector=0`, state IDLE.
- If `start` is high in cycle 0, then `busy=1` and `dut_in=0` from cycle 1.
- Each vector is held for `SETTLE+1` cycles. `dut_out` is sampled in the last of those cycles, so the gate under test has `SETTLE` full cycles to settle.
- Total sweep: `done` rises at cycle `1 + 2^N_IN*(SETTLE+1)`, counted from the cycle in which `start` was sampled. `busy` falls in the same cycle.
- `err_count`, `fail_vector` and `pass` are stable and valid whenever `done=1`.
- A restart from DONE shows `busy=1`, `done=0` and counters cleared on the very next cycle.

## Test plan
1. NOT gate with a correct inverter (`N_IN=1`, `SETTLE=2`), `start` pulsed at cycle 0 -> `dut_in` goes 0 then 1; `done` rises at cycle 7; `pass=1`, `err_count=0`, `fail_vector=0`.
2. NOT gate with the gate output stuck at 0 -> vector 0 mismatches and vector 1 matches; `err_count=1`, `fail_vector=0`, `pass=0`.
3. NOT gate replaced by a buffer -> both vectors mismatch; `err_count=2`, `fail_vector=0`. Pulse `start` again in DONE -> counters clear the next cycle and the same result repeats.
4. XOR, `N_IN=3`, `SETTLE=2`, correct XOR gate -> 8 vectors 0..7 in order, `done` at cycle 25, `pass=1`. Then corrupt only vector 5 -> `err_count=1`, `fail_vector=5`.
5. Control robustness:
   - `start` held high for the whole sweep -> exactly one sweep runs, and a restart happens only on the cycle after `done` rises.
   - `rst` asserted at cycle 4 of a sweep -> next cycle is IDLE with all outputs 0, and a later `start` gives a clean full sweep.
6. `rst` and `start` both high in the same IDLE cycle -> the block stays in IDLE and `busy` remains 0.
